// File: rtl/stream_sum_accumulator_pkg.sv
// Shared definitions for the streaming sum accumulator: adder width and
// FSM state encodings.
package stream_sum_accumulator_pkg;

   // Width of the core parallel-prefix adder datapath.
   localparam int ADD_W = 16;

   // Accumulator FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } acc_state_e;

endpackage : stream_sum_accumulator_pkg

// File: rtl/stream_sum_accumulator_adder.sv
// Existing 16-bit carry-in-less parallel-prefix adder. Group generate and
// propagate terms are combined by recursive doubling (Kogge-Stone), so each
// level doubles the span every bit position has resolved. The 17-bit result
// carries the final carry out in its MSB.
module RecursiveAdder
   import stream_sum_accumulator_pkg::*;
(
   input  logic [ADD_W-1:0] a,
   input  logic [ADD_W-1:0] b,
   output logic [ADD_W:0]   sum
);

   localparam int LVLS = $clog2(ADD_W);

   // g_s[k][i]: carry out of bit i considering bits [i : i-2^k+1].
   // p_s[k][i]: those same bits all propagate. Bit positions whose span
   // already reaches bit 0 only need g; their p is masked off by the
   // shifted operand and never affects the result.
   logic [ADD_W-1:0] g_s [0:LVLS];
   logic [ADD_W-1:0] p_s [0:LVLS-1];

   assign g_s[0] = a & b;
   assign p_s[0] = a ^ b;

   genvar lvl;
   generate
      for (lvl = 0; lvl < LVLS; lvl++) begin : g_level
         assign g_s[lvl+1] = g_s[lvl] | (p_s[lvl] & (g_s[lvl] << (1 << lvl)));
         if (lvl < LVLS - 1) begin : g_prop
            assign p_s[lvl+1] = p_s[lvl] & (p_s[lvl] << (1 << lvl));
         end
      end
   endgenerate

   // The carry into bit i is the resolved generate of bit i-1; bit 0 has
   // no carry in.
   assign sum = {g_s[LVLS][ADD_W-1], p_s[0] ^ {g_s[LVLS][ADD_W-2:0], 1'b0}};

endmodule : RecursiveAdder

// File: rtl/stream_sum_accumulator.sv
// Packetised stream accumulator. Each accepted 16-bit beat is added to the
// running low half through the prefix adder; the adder carry increments an
// HI_W-bit high half. One result per packet is presented on a valid/ready
// output one cycle after the last beat is accepted.
module stream_sum_accumulator
   import stream_sum_accumulator_pkg::*;
#(
   parameter int HI_W  = 8,
   parameter int CNT_W = 8
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADD_W-1:0]      in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADD_W+HI_W-1:0] out_sum,
   output logic [CNT_W-1:0]      out_count,
   output logic                  out_ovf
);

   acc_state_e             state_r;
   logic [ADD_W-1:0]       acc_lo_r;
   logic [HI_W-1:0]        acc_hi_r;
   logic [CNT_W-1:0]       count_r;
   logic                   ovf_r;
   logic                   out_valid_r;
   logic [ADD_W+HI_W-1:0]  out_sum_r;
   logic [CNT_W-1:0]       out_count_r;
   logic                   out_ovf_r;

   logic                   beat_s;
   logic [ADD_W-1:0]       add_a_s;
   logic [ADD_W:0]         add_sum_s;
   logic [HI_W-1:0]        hi_base_s;
   logic [HI_W-1:0]        hi_next_s;
   logic [CNT_W-1:0]       cnt_next_s;
   logic                   ovf_base_s;
   logic                   ovf_next_s;

   // Input is refused only while a finished result waits for downstream.
   assign in_ready = (state_r != ST_DONE);

   RecursiveAdder u_adder (
      .a   (add_a_s),
      .b   (in_data),
      .sum (add_sum_s)
   );

   // Select adder operand and post-beat totals; IDLE acts as a cleared accumulator.
   always_comb begin
      beat_s = in_valid && (state_r != ST_DONE);
      if (state_r == ST_IDLE) begin
         add_a_s    = {ADD_W{1'b0}};
         hi_base_s  = {HI_W{1'b0}};
         ovf_base_s = 1'b0;
         cnt_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         add_a_s    = acc_lo_r;
         hi_base_s  = acc_hi_r;
         ovf_base_s = ovf_r;
         if (count_r == {CNT_W{1'b1}}) begin
            cnt_next_s = count_r;
         end else begin
            cnt_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
      hi_next_s  = hi_base_s + {{(HI_W-1){1'b0}}, add_sum_s[ADD_W]};
      ovf_next_s = ovf_base_s | (add_sum_s[ADD_W] && (hi_base_s == {HI_W{1'b1}}));
   end

   // FSM, accumulator registers and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         acc_lo_r    <= {ADD_W{1'b0}};
         acc_hi_r    <= {HI_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         out_sum_r   <= {(ADD_W+HI_W){1'b0}};
         out_count_r <= {CNT_W{1'b0}};
         out_ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_ACCUM: begin
               if (beat_s) begin
                  acc_lo_r <= add_sum_s[ADD_W-1:0];
                  acc_hi_r <= hi_next_s;
                  count_r  <= cnt_next_s;
                  ovf_r    <= ovf_next_s;
                  if (in_last) begin
                     state_r     <= ST_DONE;
                     out_valid_r <= 1'b1;
                     out_sum_r   <= {hi_next_s, add_sum_s[ADD_W-1:0]};
                     out_count_r <= cnt_next_s;
                     out_ovf_r   <= ovf_next_s;
                  end else begin
                     state_r <= ST_ACCUM;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b0;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign out_sum   = out_sum_r;
   assign out_count = out_count_r;
   assign out_ovf   = out_ovf_r;

endmodule : stream_sum_accumulator
